// File: rtl/reg_file_sb.sv
// Register file with two prioritised write ports, optional zero register and bypass,
// an auxiliary register, and a per-register pending scoreboard for multi-cycle producers.
`timescale 1ns/1ps
module reg_file_sb #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic [D-1:0]      waddr_a,
  input  logic [W-1:0]      wdata_a,
  input  logic              we_b,
  input  logic [D-1:0]      waddr_b,
  input  logic [W-1:0]      wdata_b,
  input  logic [D-1:0]      raddrA,
  input  logic [D-1:0]      raddrB,
  output logic [W-1:0]      data_outA,
  output logic [W-1:0]      data_outB,
  output logic              validA,
  output logic              validB,
  input  logic              rsv_en,
  input  logic [D-1:0]      rsv_addr,
  input  logic              aux_we,
  input  logic [W-1:0]      aux_in,
  output logic [W-1:0]      aux_out,
  output logic [2**D-1:0]   pending
);

  localparam int NREG = 2**D;

  logic [W-1:0]    mem_q [NREG];
  logic [W-1:0]    mem_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [W-1:0]    aux_q;
  logic [W-1:0]    aux_d;

  // Port B is applied first so port A overwrites it on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (we_b) mem_d[waddr_b] = wdata_b;
    if (we_a) mem_d[waddr_a] = wdata_a;
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  // Writes retire a reservation; a same-cycle reserve is applied last so it wins.
  always_comb begin
    pend_d = pend_q;
    if (we_b) pend_d[waddr_b] = 1'b0;
    if (we_a) pend_d[waddr_a] = 1'b0;
    if (rsv_en) pend_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_comb begin
    aux_d = aux_q;
    if (aux_we) aux_d = aux_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      pend_q <= '0;
      aux_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      aux_q  <= aux_d;
    end
  end

  always_comb begin
    data_outA = mem_q[raddrA];
    validA    = ~pend_q[raddrA];
    if (BYPASS != 0) begin
      if (we_a && (waddr_a == raddrA)) begin
        data_outA = wdata_a;
        validA    = 1'b1;
      end else if (we_b && (waddr_b == raddrA)) begin
        data_outA = wdata_b;
        validA    = 1'b1;
      end
    end
    if ((ZERO_REG != 0) && (raddrA == '0)) begin
      data_outA = '0;
      validA    = 1'b1;
    end
  end

  always_comb begin
    data_outB = mem_q[raddrB];
    validB    = ~pend_q[raddrB];
    if (BYPASS != 0) begin
      if (we_a && (waddr_a == raddrB)) begin
        data_outB = wdata_a;
        validB    = 1'b1;
      end else if (we_b && (waddr_b == raddrB)) begin
        data_outB = wdata_b;
        validB    = 1'b1;
      end
    end
    if ((ZERO_REG != 0) && (raddrB == '0)) begin
      data_outB = '0;
      validB    = 1'b1;
    end
  end

  assign aux_out = aux_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build plus ZERO_REG=0 and BYPASS=0 builds
// sharing the same stimulus so their differing responses can be compared side by side.
`timescale 1ns/1ps
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b, rsv_en, aux_we;
  logic [3:0]  waddr_a, waddr_b, raddrA, raddrB, rsv_addr;
  logic [7:0]  wdata_a, wdata_b, aux_in;

  logic [7:0]  d_outA, d_outB, d_aux;
  logic        d_validA, d_validB;
  logic [15:0] d_pend;

  logic [7:0]  nz_outA, nz_outB, nz_aux;
  logic        nz_validA, nz_validB;
  logic [15:0] nz_pend;

  logic [7:0]  nb_outA, nb_outB, nb_aux;
  logic        nb_validA, nb_validB;
  logic [15:0] nb_pend;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.W(8), .D(4), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(d_outA), .data_outB(d_outB), .validA(d_validA), .validB(d_validB),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .aux_we(aux_we), .aux_in(aux_in), .aux_out(d_aux), .pending(d_pend)
  );

  reg_file_sb #(.W(8), .D(4), .ZERO_REG(0), .BYPASS(1)) u_nz (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(nz_outA), .data_outB(nz_outB), .validA(nz_validA), .validB(nz_validB),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .aux_we(aux_we), .aux_in(aux_in), .aux_out(nz_aux), .pending(nz_pend)
  );

  reg_file_sb #(.W(8), .D(4), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(nb_outA), .data_outB(nb_outB), .validA(nb_validA), .validB(nb_validB),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .aux_we(aux_we), .aux_in(aux_in), .aux_out(nb_aux), .pending(nb_pend)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; rsv_en = 0; aux_we = 0;
    waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0;
    rsv_addr = 0; aux_in = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    raddrA = 4'd3; raddrB = 4'd3;
    we_a = 1; waddr_a = 4'd3; wdata_a = 8'hAA;
    rsv_en = 1; rsv_addr = 4'd3;
    aux_we = 1; aux_in = 8'h55;
    tick(); tick();
    reset = 0;
    idle();
    #1;
    total_cnt++;
    if (d_outA !== 8'h00) $display("[TB] FAIL reset_dataA: got %h expected %h", d_outA, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (d_validA !== 1'b1) $display("[TB] FAIL reset_validA: got %b expected %b", d_validA, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (d_pend !== 16'h0000) $display("[TB] FAIL reset_pending: got %h expected %h", d_pend, 16'h0000);
    else pass_cnt++;
    total_cnt++;
    if (d_aux !== 8'h00) $display("[TB] FAIL reset_aux: got %h expected %h", d_aux, 8'h00);
    else pass_cnt++;
  endtask

  task automatic test_dual_write();
    we_a = 1; waddr_a = 4'd5; wdata_a = 8'h11;
    we_b = 1; waddr_b = 4'd5; wdata_b = 8'h22;
    raddrA = 4'd5;
    #1;
    total_cnt++;
    if (d_outA !== 8'h11) $display("[TB] FAIL dual_bypass: got %h expected %h", d_outA, 8'h11);
    else pass_cnt++;
    total_cnt++;
    if (nb_outA !== 8'h00) $display("[TB] FAIL dual_nobypass_old: got %h expected %h", nb_outA, 8'h00);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_outA !== 8'h11) $display("[TB] FAIL dual_stored: got %h expected %h", d_outA, 8'h11);
    else pass_cnt++;
    // port B alone to a different address must still land
    we_b = 1; waddr_b = 4'd6; wdata_b = 8'h66; raddrB = 4'd6;
    tick();
    idle();
    #1;
    total_cnt++;
    if (nb_outB !== 8'h66) $display("[TB] FAIL portb_stored: got %h expected %h", nb_outB, 8'h66);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 4'd7; raddrB = 4'd7;
    #1;
    total_cnt++;
    if (d_validB !== 1'b1) $display("[TB] FAIL rsv_same_cycle_validB: got %b expected %b", d_validB, 1'b1);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_pend[7] !== 1'b1) $display("[TB] FAIL rsv_pending7: got %b expected %b", d_pend[7], 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (d_validB !== 1'b0) $display("[TB] FAIL rsv_validB: got %b expected %b", d_validB, 1'b0);
    else pass_cnt++;
    we_b = 1; waddr_b = 4'd7; wdata_b = 8'h5C;
    #1;
    total_cnt++;
    if (d_validB !== 1'b1) $display("[TB] FAIL wb_bypass_validB: got %b expected %b", d_validB, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (d_outB !== 8'h5C) $display("[TB] FAIL wb_bypass_dataB: got %h expected %h", d_outB, 8'h5C);
    else pass_cnt++;
    total_cnt++;
    if (nb_validB !== 1'b0) $display("[TB] FAIL wb_nobypass_validB: got %b expected %b", nb_validB, 1'b0);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_pend !== 16'h0000) $display("[TB] FAIL wb_clear_pending: got %h expected %h", d_pend, 16'h0000);
    else pass_cnt++;
  endtask

  task automatic test_reserve_and_write();
    rsv_en = 1; rsv_addr = 4'd9;
    we_a = 1; waddr_a = 4'd9; wdata_a = 8'h33;
    raddrA = 4'd9;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_pend !== 16'h0200) $display("[TB] FAIL rw_pending: got %h expected %h", d_pend, 16'h0200);
    else pass_cnt++;
    total_cnt++;
    if (d_outA !== 8'h33) $display("[TB] FAIL rw_data: got %h expected %h", d_outA, 8'h33);
    else pass_cnt++;
    total_cnt++;
    if (d_validA !== 1'b0) $display("[TB] FAIL rw_validA: got %b expected %b", d_validA, 1'b0);
    else pass_cnt++;
    rsv_en = 1; rsv_addr = 4'd9;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_pend !== 16'h0200) $display("[TB] FAIL rsv_again_pending: got %h expected %h", d_pend, 16'h0200);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    we_a = 1; waddr_a = 4'd0; wdata_a = 8'hFF;
    rsv_en = 1; rsv_addr = 4'd0;
    raddrA = 4'd0;
    #1;
    total_cnt++;
    if (d_outA !== 8'h00) $display("[TB] FAIL zero_same_cycle: got %h expected %h", d_outA, 8'h00);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_outA !== 8'h00) $display("[TB] FAIL zero_data: got %h expected %h", d_outA, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (d_validA !== 1'b1) $display("[TB] FAIL zero_validA: got %b expected %b", d_validA, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (d_pend[0] !== 1'b0) $display("[TB] FAIL zero_pending0: got %b expected %b", d_pend[0], 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (nz_outA !== 8'hFF) $display("[TB] FAIL nozero_data: got %h expected %h", nz_outA, 8'hFF);
    else pass_cnt++;
    total_cnt++;
    if (nz_pend[0] !== 1'b1) $display("[TB] FAIL nozero_pending0: got %b expected %b", nz_pend[0], 1'b1);
    else pass_cnt++;
  endtask

  task automatic test_no_bypass_and_aux();
    we_a = 1; waddr_a = 4'd2; wdata_a = 8'h44; raddrA = 4'd2;
    aux_we = 1; aux_in = 8'h9E;
    #1;
    total_cnt++;
    if (nb_outA !== 8'h00) $display("[TB] FAIL nobypass_old: got %h expected %h", nb_outA, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (d_aux !== 8'h00) $display("[TB] FAIL aux_not_bypassed: got %h expected %h", d_aux, 8'h00);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (nb_outA !== 8'h44) $display("[TB] FAIL nobypass_new: got %h expected %h", nb_outA, 8'h44);
    else pass_cnt++;
    total_cnt++;
    if (d_aux !== 8'h9E) $display("[TB] FAIL aux_loaded: got %h expected %h", d_aux, 8'h9E);
    else pass_cnt++;
    we_a = 1; waddr_a = 4'd4; wdata_a = 8'h77;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_aux !== 8'h9E) $display("[TB] FAIL aux_hold: got %h expected %h", d_aux, 8'h9E);
    else pass_cnt++;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation ran past its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1;
    idle();
    raddrA = 0; raddrB = 0;
    test_reset();
    test_dual_write();
    test_scoreboard();
    test_reserve_and_write();
    test_zero_reg();
    test_no_bypass_and_aux();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
